// File: rtl/scoreboard_pkg.sv
// Shared constants for the scoreboard display path: segment patterns,
// digit scan positions, conversion FSM states and helper functions.
package scoreboard_pkg;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   localparam logic [1:0] DIG_P1_TENS  = 2'd0;
   localparam logic [1:0] DIG_P1_UNITS = 2'd1;
   localparam logic [1:0] DIG_P2_TENS  = 2'd2;
   localparam logic [1:0] DIG_P2_UNITS = 2'd3;

   localparam int MAX_SCORE_DEF = 99;

   typedef enum logic [1:0] {IDLE, CONV_P1, CONV_P2, COMMIT} state_e;

   function automatic logic [6:0] seg_enc(input logic [3:0] d);
      case (d)
         4'd0:    seg_enc = SEG_0;
         4'd1:    seg_enc = SEG_1;
         4'd2:    seg_enc = SEG_2;
         4'd3:    seg_enc = SEG_3;
         4'd4:    seg_enc = SEG_4;
         4'd5:    seg_enc = SEG_5;
         4'd6:    seg_enc = SEG_6;
         4'd7:    seg_enc = SEG_7;
         4'd8:    seg_enc = SEG_8;
         4'd9:    seg_enc = SEG_9;
         default: seg_enc = SEG_BLANK;
      endcase
   endfunction

   function automatic logic [7:0] clamp_score(input logic [7:0] v, input logic [7:0] mx);
      clamp_score = (v > mx) ? mx : v;
   endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble: one add-3/shift step per cycle, 8 steps per byte.
// Inputs are pre-clamped to <= 99, so two BCD digits are enough.
module bin2bcd_serial
   import scoreboard_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic [7:0] bin_i,
   output logic [3:0] tens_o,
   output logic [3:0] units_o,
   output logic       busy_o,
   output logic       done_o
);

   logic [7:0] bcd_q, bcd_d, sh_q, sh_d, src_bcd, src_sh;
   logic [2:0] cnt_q, cnt_d;
   logic       run_q, run_d;

   function automatic logic [3:0] add3(input logic [3:0] n);
      add3 = (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   // Step datapath; the start cycle performs the first step straight from bin_i.
   always_comb begin
      src_bcd = start_i ? 8'h00 : bcd_q;
      src_sh  = start_i ? bin_i : sh_q;
      bcd_d   = bcd_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      run_d   = run_q;
      if (start_i || run_q)
         {bcd_d, sh_d} = {add3(src_bcd[7:4]), add3(src_bcd[3:0]), src_sh} << 1;
      if (start_i) begin
         run_d = 1'b1;
         cnt_d = 3'd1;
      end else if (run_q) begin
         cnt_d = cnt_q + 3'd1;
         if (cnt_q == 3'd7) run_d = 1'b0;
      end
   end

   // Converter state registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bcd_q <= '0;
         sh_q  <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         bcd_q <= bcd_d;
         sh_q  <= sh_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

   assign tens_o  = bcd_q[7:4];
   assign units_o = bcd_q[3:0];
   assign busy_o  = run_q;
   // High during the cycle whose edge writes the final step.
   assign done_o  = run_q && (cnt_q == 3'd7);

endmodule

// File: rtl/scoreboard_display_driver.sv
// Converts two binary scores to BCD and scans them onto a 4-digit
// multiplexed 7-segment display. Optional leading-zero blanking of the
// tens digits is enabled with the macro SCOREBOARD_LZ_BLANK_EN.
module scoreboard_display_driver
   import scoreboard_pkg::*;
#(
   parameter int SCAN_DIV  = 1000,
   parameter int MAX_SCORE = MAX_SCORE_DEF
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] p1_score_i,
   input  logic [7:0] p2_score_i,
   output logic [6:0] seg_o,
   output logic [3:0] digit_en_o,
   output logic       busy_o
);

   localparam logic [7:0]  MAX_V  = 8'(MAX_SCORE);
   localparam logic [15:0] PRE_TC = 16'(SCAN_DIV - 1);

   state_e           state_q, state_d;
   logic [7:0]       sh_p1_q, sh_p1_d, sh_p2_q, sh_p2_d, p1_bcd_q, p1_bcd_d;
   logic [3:0][3:0]  disp_q, disp_d;
   logic [7:0]       p1_c, p2_c, cv_bin;
   logic             cv_start, cv_busy, cv_done;
   logic [3:0]       cv_tens, cv_units;
   logic [15:0]      pre_q;
   logic [1:0]       idx_q;
   logic [3:0]       dig_val, en_d, en_q;
   logic [6:0]       seg_d, seg_q;

   assign p1_c = clamp_score(p1_score_i, MAX_V);
   assign p2_c = clamp_score(p2_score_i, MAX_V);

   bin2bcd_serial u_conv (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (cv_start),
      .bin_i   (cv_bin),
      .tens_o  (cv_tens),
      .units_o (cv_units),
      .busy_o  (cv_busy),
      .done_o  (cv_done)
   );

   // Conversion sequencing: detect change, convert P1 then P2, commit both at once.
   always_comb begin
      state_d  = state_q;
      sh_p1_d  = sh_p1_q;
      sh_p2_d  = sh_p2_q;
      p1_bcd_d = p1_bcd_q;
      disp_d   = disp_q;
      cv_start = 1'b0;
      cv_bin   = sh_p1_q;
      case (state_q)
         IDLE: begin
            if ((p1_c != sh_p1_q) || (p2_c != sh_p2_q)) begin
               sh_p1_d = p1_c;
               sh_p2_d = p2_c;
               state_d = CONV_P1;
            end
         end
         CONV_P1: begin
            cv_start = !cv_busy;
            cv_bin   = sh_p1_q;
            if (cv_done) state_d = CONV_P2;
         end
         CONV_P2: begin
            cv_start = !cv_busy;
            cv_bin   = sh_p2_q;
            // P1 result is still in the converter on P2's start cycle.
            if (!cv_busy) p1_bcd_d = {cv_tens, cv_units};
            if (cv_done) state_d = COMMIT;
         end
         COMMIT: begin
            disp_d  = {cv_units, cv_tens, p1_bcd_q[3:0], p1_bcd_q[7:4]};
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM, shadow and display registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         sh_p1_q  <= '0;
         sh_p2_q  <= '0;
         p1_bcd_q <= '0;
         disp_q   <= '0;
      end else begin
         state_q  <= state_d;
         sh_p1_q  <= sh_p1_d;
         sh_p2_q  <= sh_p2_d;
         p1_bcd_q <= p1_bcd_d;
         disp_q   <= disp_d;
      end
   end

   // Scan prescaler and digit index; runs regardless of conversion state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pre_q <= '0;
         idx_q <= DIG_P1_TENS;
      end else if (pre_q == PRE_TC) begin
         pre_q <= '0;
         idx_q <= idx_q + 2'd1;
      end else begin
         pre_q <= pre_q + 16'd1;
      end
   end

   // Segment/enable decode for the currently selected digit.
   always_comb begin
      dig_val = disp_q[idx_q];
      en_d    = 4'b0001 << idx_q;
      seg_d   = seg_enc(dig_val);
`ifdef SCOREBOARD_LZ_BLANK_EN
      if (((idx_q == DIG_P1_TENS) || (idx_q == DIG_P2_TENS)) && (dig_val == 4'd0))
         seg_d = SEG_BLANK;
`endif
   end

   // Registered display outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         en_q  <= 4'b0001;
         seg_q <= SEG_0;
      end else begin
         en_q  <= en_d;
         seg_q <= seg_d;
      end
   end

   assign seg_o      = seg_q;
   assign digit_en_o = en_q;
   assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_scoreboard_display_driver.sv
// Directed bench for scoreboard_display_driver with a short scan period.
module tb_scoreboard_display_driver;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] p1, p2;
   logic [6:0] seg;
   logic [3:0] en;
   logic       busy;
   int         n_cmp = 0;
   int         n_err = 0;

`ifdef SCOREBOARD_LZ_BLANK_EN
   localparam logic [6:0] T0 = 7'h00;
`else
   localparam logic [6:0] T0 = 7'h3F;
`endif

   scoreboard_display_driver #(.SCAN_DIV(4)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .p1_score_i (p1),
      .p2_score_i (p2),
      .seg_o      (seg),
      .digit_en_o (en),
      .busy_o     (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] pick(input logic [3:0] e, input logic [6:0] a, b, c, d);
      pick = (e == 4'b0001) ? a : (e == 4'b0010) ? b : (e == 4'b0100) ? c : d;
   endfunction

   // n cycles of scan: one-hot enable and the expected segment for the lit digit
   task automatic chk_scan(input string tag, input logic [6:0] a, b, c, d, input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         chk({tag, "_onehot"}, 32'($onehot(en)), 32'd1);
         chk({tag, "_seg"}, 32'(seg), 32'(pick(en, a, b, c, d)));
      end
   endtask

   task automatic wait_idle(input string tag, input int bound);
      int i = 0;
      while (busy && i < bound) begin
         tick();
         i++;
      end
      chk({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      logic [3:0] ex;
      int         i;
      logic       saw_busy;

      // ---- reset and scan rotation ----
      rst = 1'b1; p1 = 8'd0; p2 = 8'd0;
      tick(); tick();
      chk("rst_en", 32'(en), 32'h1);
      chk("rst_seg", 32'(seg), 32'h3F);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("scan_first_en", 32'(en), 32'h1);
      end
      i = 0;
      while (en != 4'b0010 && i < 8) begin
         tick();
         i++;
      end
      for (int k = 0; k < 16; k++) begin
         if (k > 0) tick();
         ex = 4'b0001 << ((1 + k / 4) % 4);
         chk("scan_en", 32'(en), 32'(ex));
         chk("scan_seg", 32'(seg), 32'h3F);
         chk("scan_busy", 32'(busy), 32'd0);
      end

      // ---- 42 / 7: busy window T+1..T+17, then digits ----
      p1 = 8'd42; p2 = 8'd7;
      for (int k = 1; k <= 17; k++) begin
         tick();
         chk("conv42_busy", 32'(busy), 32'd1);
      end
      tick();
      chk("conv42_busy_end", 32'(busy), 32'd0);
      chk_scan("d42_7", 7'h66, 7'h5B, T0, 7'h07, 16);

      // ---- clamp 150 / 255 -> 99 / 99 ----
      p1 = 8'd150; p2 = 8'd255;
      tick();
      wait_idle("clamp", 40);
      chk_scan("d99_99", 7'h6F, 7'h6F, 7'h6F, 7'h6F, 16);
      chk("clamp_sh1", 32'(dut.sh_p1_q), 32'd99);
      chk("clamp_sh2", 32'(dut.sh_p2_q), 32'd99);

      // ---- 12 then 34 mid-conversion: two back-to-back conversions ----
      p1 = 8'd12; p2 = 8'd5;
      for (int k = 1; k <= 52; k++) begin
         tick();
         if (k == 5) p1 = 8'd34;
         chk("requeue_busy", 32'(busy),
             32'(((k >= 1 && k <= 17) || (k >= 19 && k <= 35)) ? 1 : 0));
         if (k >= 19 && k <= 36)
            chk("requeue_12", 32'(seg), 32'(pick(en, 7'h06, 7'h5B, T0, 7'h6D)));
         else if (k >= 37)
            chk("requeue_34", 32'(seg), 32'(pick(en, 7'h4F, 7'h66, T0, 7'h6D)));
      end

      // ---- reset mid-conversion ----
      p1 = 8'd88; p2 = 8'd77;
      for (int k = 1; k <= 10; k++) tick();
      chk("abort_busy_pre", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_en", 32'(en), 32'h1);
      chk("abort_seg", 32'(seg), 32'h3F);
      chk("abort_disp", 32'(dut.disp_q), 32'h0);
      chk("abort_sh1", 32'(dut.sh_p1_q), 32'd0);
      p1 = 8'd0; p2 = 8'd0;
      tick();
      rst = 1'b0;
      chk_scan("abort_zero", 7'h3F, 7'h3F, T0, 7'h3F, 20);
      chk("abort_disp_after", 32'(dut.disp_q), 32'h0);
      chk("abort_idle", 32'(busy), 32'd0);

      // ---- hold inputs: no spurious reconversion ----
      p1 = 8'd9; p2 = 8'd3;
      tick();
      wait_idle("hold", 40);
      chk_scan("d09_03", T0, 7'h6F, T0, 7'h4F, 16);
      saw_busy = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         tick();
         if (busy) saw_busy = 1'b1;
      end
      chk("hold_no_busy", 32'(saw_busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/scoreboard_display_driver.md
Name: scoreboard_display_driver

Overview:
Display-side counterpart of the scoreboard score controller. It consumes the two 8-bit binary player scores and converts each to two BCD digits with a serial double-dabble converter. It then drives a 4-digit multiplexed common-bus 7-segment display. It sits between the score controller outputs and the top-level segment/digit pins.

Parameters:
SCAN_DIV, 1000, clock cycles each digit stays enabled before the scan advances (legal range 1..65535).
MAX_SCORE, 99, clamp value; any input greater than this is displayed as MAX_SCORE.

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous reset, active-high
p1_score_i  input  8  player 1 score, binary
p2_score_i  input  8  player 2 score, binary
seg_o  output  7  segments, active-high; bit0=a through bit6=g
digit_en_o  output  4  one-hot digit enable, active-high; bit0=P1 tens, bit1=P1 units, bit2=P2 tens, bit3=P2 units
busy_o  output  1  high while a conversion is in progress (states CONV_P1, CONV_P2, COMMIT)

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - all shadow and display BCD registers = 0
  - scan index = 0, prescaler = 0
  - digit_en_o = 4'b0001, seg_o = 7'h3F, busy_o = 0
  - FSM goes to IDLE
- Reset mid-conversion: the conversion is aborted and nothing is committed.
- Conversion FSM:
  - IDLE: each cycle, compare the clamped inputs against the shadow registers. If either differs at cycle T, capture both clamped values into the shadows and go to CONV_P1.
  - CONV_P1: 8 shift/add-3 cycles (T+1..T+8).
  - CONV_P2: 8 cycles (T+9..T+16).
  - COMMIT: one cycle (T+17). Writes all four display BCD registers atomically, then returns to IDLE.
- Display timing: the display registers hold new values from T+18. seg_o shows a new digit from T+19 if that digit is enabled.
- Input changes while busy_o=1 are ignored. Re-detection occurs in IDLE on the first cycle after COMMIT.
- Clamp: a value > MAX_SCORE is replaced with MAX_SCORE before conversion (150 -> 99, 255 -> 99).
- Scan:
  - The prescaler counts 0..SCAN_DIV-1. On wrap, the scan index advances 0->1->2->3->0.
  - SCAN_DIV=1 advances every cycle.
- Output registers: digit_en_o and seg_o are registered from the current index and display registers, one cycle after the index changes. Exactly one digit_en_o bit is high at all times.
- Segment encoding: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F. BCD values >9 map to 00 (unreachable).
- Scanning never stalls during conversion; the old values are shown until COMMIT.

Optional Feature:
Macro: SCOREBOARD_LZ_BLANK_EN
- Defined: a tens digit of 0 drives seg_o = 7'h00 while its digit is enabled. Units digits are never blanked, so a score of 0 shows as a single "0".
- Undefined: all four digits always display, including leading zeros.

Decomposition:
- Package scoreboard_pkg: SEG_* constants for 0-9 and blank; digit index encoding (DIG_P1_TENS..DIG_P2_UNITS); MAX_SCORE default; FSM state encoding (IDLE, CONV_P1, CONV_P2, COMMIT).
- Sub-module bin2bcd_serial: 8-bit in, tens/units BCD out, start/done handshake, fixed 8-cycle latency. Instantiated once and reused for P1 then P2.

Test Plan:
- Reset: assert rst_i 2 cycles, release, SCAN_DIV=4 -> digit_en_o sequences 0001,0010,0100,1000, each held 4 cycles; seg_o=3F throughout; busy_o=0.
- p1=42, p2=7 changed at cycle T -> busy_o high T+1..T+17; once digits refresh, seg_o per digit = 66,5B,3F,07 (with SCOREBOARD_LZ_BLANK_EN the third digit = 00).
- p1=150, p2=255 -> all four digits show 6F; shadow registers hold 99.
- p1=12 set at T, changed to 34 at T+5 -> first commit at T+17 shows 12; a second conversion starts at T+18 and commits 34 at T+35.
- rst_i asserted at T+10 mid-conversion -> next cycle all outputs at reset values; no commit; display registers stay 0.
- Hold inputs constant for 1000 cycles after a conversion -> busy_o never rises again (no spurious reconversion).
